// File: rtl/cache_access_arbiter_if.sv
// rtl/cache_access_arbiter_if.sv - Requester, cache and memory signal bundle for cache_access_arbiter.
// master is the arbiter's view; slave is the view of the core/cache/memory around it.
interface cache_access_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 16
);
  localparam int LW = LINE_BYTES * 8;

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [1:0]        p0_size;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [1:0]        c_size;
  logic              c_read;
  logic              c_write;
  logic              c_load;
  logic [LW-1:0]     c_load_data;
  logic              c_save_ready;
  logic              c_status_ready;
  logic              c_hit;
  logic [DATA_W-1:0] c_rdata;
  logic              c_save_data;
  logic [LW-1:0]     c_wb_data;
  logic [ADDR_W-1:0] c_wb_addr;
  logic              c_load_complete;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LW-1:0]     mem_wdata;
  logic              mem_ready;
  logic [LW-1:0]     mem_rdata;

  modport master (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    output p0_ack, p0_rdata, p0_err,
    input  p1_req, p1_addr,
    output p1_ack, p1_rdata, p1_err,
    output c_addr, c_wdata, c_size, c_read, c_write, c_load, c_load_data, c_save_ready,
    input  c_status_ready, c_hit, c_rdata, c_save_data, c_wb_data, c_wb_addr, c_load_complete,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    input  p0_ack, p0_rdata, p0_err,
    output p1_req, p1_addr,
    input  p1_ack, p1_rdata, p1_err,
    input  c_addr, c_wdata, c_size, c_read, c_write, c_load, c_load_data, c_save_ready,
    output c_status_ready, c_hit, c_rdata, c_save_data, c_wb_data, c_wb_addr, c_load_complete,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/cache_access_arbiter.sv
// rtl/cache_access_arbiter.sv - L1 front-end arbiter and miss sequencer (fill, load, write-back, replay).
// Optional CACHE_ARB_RR_EN selects round-robin arbitration instead of fixed port-0 priority.
module cache_access_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int OFF_W      = 4
) (
  input  logic clk,
  input  logic rst,
  cache_access_arbiter_if.master bus
);
  localparam int LW = LINE_BYTES * 8;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, LOAD, WB, RESP} state_t;

  state_t state;
  logic   sel;
  logic   we;
  logic   replay;
  logic   gnt_port;
  logic   gnt_any;

  assign gnt_any = bus.p0_req | bus.p1_req;

`ifdef CACHE_ARB_RR_EN
  logic rr_ptr;
  always_comb begin
    gnt_port = !bus.p0_req;
    if (bus.p0_req && bus.p1_req) gnt_port = rr_ptr;
  end
`else
  always_comb begin
    gnt_port = !bus.p0_req;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      sel              <= 1'b0;
      we               <= 1'b0;
      replay           <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      rr_ptr           <= 1'b0;
`endif
      bus.p0_ack       <= 1'b0;
      bus.p0_rdata     <= {DATA_W{1'b0}};
      bus.p0_err       <= 1'b0;
      bus.p1_ack       <= 1'b0;
      bus.p1_rdata     <= {DATA_W{1'b0}};
      bus.p1_err       <= 1'b0;
      bus.c_addr       <= {ADDR_W{1'b0}};
      bus.c_wdata      <= {DATA_W{1'b0}};
      bus.c_size       <= 2'd0;
      bus.c_read       <= 1'b0;
      bus.c_write      <= 1'b0;
      bus.c_load       <= 1'b0;
      bus.c_load_data  <= {LW{1'b0}};
      bus.c_save_ready <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= {ADDR_W{1'b0}};
      bus.mem_wdata    <= {LW{1'b0}};
    end else begin
      bus.p0_ack       <= 1'b0;
      bus.p1_ack       <= 1'b0;
      bus.c_save_ready <= 1'b0;
      case (state)
        IDLE: if (gnt_any) begin
          sel         <= gnt_port;
          we          <= !gnt_port && bus.p0_we;
          bus.c_addr  <= gnt_port ? bus.p1_addr : bus.p0_addr;
          bus.c_wdata <= gnt_port ? {DATA_W{1'b0}} : bus.p0_wdata;
          bus.c_size  <= gnt_port ? 2'd0 : bus.p0_size;
          bus.c_read  <= gnt_port || !bus.p0_we;
          bus.c_write <= !gnt_port && bus.p0_we;
`ifdef CACHE_ARB_RR_EN
          rr_ptr      <= !gnt_port;
`endif
          state       <= LOOKUP;
        end
        LOOKUP: if (bus.c_status_ready) begin
          bus.c_read  <= 1'b0;
          bus.c_write <= 1'b0;
          // A miss after the line was just loaded is reported, not retried.
          if (bus.c_hit || replay) begin
            bus.p0_ack   <= !sel;
            bus.p1_ack   <= sel;
            bus.p0_rdata <= (!sel && bus.c_hit) ? bus.c_rdata : {DATA_W{1'b0}};
            bus.p1_rdata <= (sel && bus.c_hit) ? bus.c_rdata : {DATA_W{1'b0}};
            bus.p0_err   <= !sel && !bus.c_hit;
            bus.p1_err   <= sel && !bus.c_hit;
            state        <= RESP;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.c_addr & LINE_MASK;
            state        <= FILL;
          end
        end
        FILL: if (bus.mem_ready) begin
          bus.mem_req     <= 1'b0;
          bus.c_load_data <= bus.mem_rdata;
          bus.c_load      <= 1'b1;
          state           <= LOAD;
        end
        LOAD: begin
          // c_save_data may still be high in the c_save_ready cycle; it is stale then.
          if (bus.c_save_data && !bus.c_save_ready) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= bus.c_wb_addr & LINE_MASK;
            bus.mem_wdata <= bus.c_wb_data;
            state         <= WB;
          end else if (bus.c_load_complete) begin
            bus.c_load  <= 1'b0;
            bus.c_read  <= !we;
            bus.c_write <= we;
            replay      <= 1'b1;
            state       <= LOOKUP;
          end
        end
        WB: if (bus.mem_ready) begin
          bus.mem_req      <= 1'b0;
          bus.mem_we       <= 1'b0;
          bus.c_save_ready <= 1'b1;
          state            <= LOAD;
        end
        RESP: begin
          bus.p0_rdata <= {DATA_W{1'b0}};
          bus.p1_rdata <= {DATA_W{1'b0}};
          bus.p0_err   <= 1'b0;
          bus.p1_err   <= 1'b0;
          replay       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_access_arbiter.sv
// tb/tb_cache_access_arbiter.sv - Scoreboard bench for cache_access_arbiter (hit, miss, write-back, replay error, reset).
module tb_cache_access_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int OFF_W      = 4;
  localparam int LW         = LINE_BYTES * 8;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  resp_t q0[$];
  resp_t q1[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  logic  exp_ptr = 1'b0;

  always #5 clk = ~clk;

  cache_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES)) bus ();

  cache_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES), .OFF_W(OFF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic port, input logic [DATA_W-1:0] d, input logic e);
    resp_t r;
    r.rdata = d;
    r.err   = e;
    if (port) q1.push_back(r);
    else      q0.push_back(r);
  endtask

  function automatic logic pick(input logic r0, input logic r1);
    if (r0 && r1) return RR_EN ? exp_ptr : 1'b0;
    return r1 && !r0;
  endfunction

  task automatic wait_ack(input logic port, input string tag);
    int n = 0;
    while (((port ? bus.p1_ack : bus.p0_ack) !== 1'b1) && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, port ? bus.p1_ack : bus.p0_ack, 1);
  endtask

  task automatic wait_mem(input logic wr, input string tag);
    int n = 0;
    while (!(bus.mem_req === 1'b1 && bus.mem_we === wr) && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, bus.mem_req, 1);
  endtask

  // Ack monitor: pops the per-port scoreboard and tracks the expected RR pointer.
  always @(negedge clk) begin
    resp_t r;
    if (!rst) begin
      exp_ptr = 1'b0;
    end else begin
      if (bus.p0_ack && bus.p1_ack) check_eq("both_acks", 1, 0);
      if (bus.p0_ack) begin
        if (q0.size() == 0) check_eq("p0_unexpected_ack", 1, 0);
        else begin
          r = q0.pop_front();
          check_eq("p0_rdata", bus.p0_rdata, r.rdata);
          check_eq("p0_err", bus.p0_err, r.err);
        end
        if (RR_EN) exp_ptr = 1'b1;
      end
      if (bus.p1_ack) begin
        if (q1.size() == 0) check_eq("p1_unexpected_ack", 1, 0);
        else begin
          r = q1.pop_front();
          check_eq("p1_rdata", bus.p1_rdata, r.rdata);
          check_eq("p1_err", bus.p1_err, r.err);
        end
        if (RR_EN) exp_ptr = 1'b0;
      end
    end
  end

  initial begin
    logic          w;
    logic          l;
    int            t_first;
    int            n;
    logic [LW-1:0] line_a;
    logic [LW-1:0] line_b;
    logic [LW-1:0] line_c;
    line_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    line_b = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    line_c = 128'hD1D1_D2D2_D3D3_D4D4_D5D5_D6D6_D7D7_D8D8;

    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_size = 0;
    bus.p1_req = 0; bus.p1_addr = '0;
    bus.c_status_ready = 0; bus.c_hit = 0; bus.c_rdata = '0; bus.c_save_data = 0;
    bus.c_wb_data = '0; bus.c_wb_addr = '0; bus.c_load_complete = 0;
    bus.mem_ready = 0; bus.mem_rdata = '0;

    repeat (3) tick();
    check_eq("rst_acks", {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 0);
    check_eq("rst_cache_ctl", {bus.c_read, bus.c_write, bus.c_load, bus.c_save_ready}, 0);
    check_eq("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr}, 0);
    check_eq("rst_c_addr", bus.c_addr, 0);
    rst = 1;
    tick();

    // Plain hit on port 0.
    bus.c_status_ready = 1; bus.c_hit = 1; bus.c_rdata = 32'hDEADBEEF;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h100; bus.p0_size = 0;
    push_exp(0, 32'hDEADBEEF, 0);
    tick();
    check_eq("t1_c_read", bus.c_read, 1);
    check_eq("t1_c_addr", bus.c_addr, 32'h100);
    tick();
    check_eq("t1_ack_latency", bus.p0_ack, 1);
    bus.p0_req = 0;
    tick();

    // Simultaneous requests, loser waits for the next IDLE.
    w = pick(1, 1);
    l = ~w;
    bus.c_rdata = 32'hA0A0_0001;
    push_exp(w, 32'hA0A0_0001, 0);
    push_exp(l, 32'hB0B0_0002, 0);
    bus.p0_req = 1; bus.p0_addr = 32'h104; bus.p1_req = 1; bus.p1_addr = 32'h2000;
    wait_ack(w, "t2_first_ack");
    t_first = cyc;
    if (w) bus.p1_req = 0; else bus.p0_req = 0;
    bus.c_rdata = 32'hB0B0_0002;
    wait_ack(l, "t2_second_ack");
    check_eq("t2_ack_spacing", cyc - t_first, 3);
    bus.p0_req = 0; bus.p1_req = 0;
    tick();

    // Back-to-back dual requests with both held.
    bus.p0_req = 1; bus.p1_req = 1;
    for (int i = 0; i < 3; i++) begin
      w = pick(1, 1);
      bus.c_rdata = 32'h0B0B_0000 + i;
      push_exp(w, 32'h0B0B_0000 + i, 0);
      n = 0;
      while (!(bus.p0_ack || bus.p1_ack) && n < 200) begin tick(); n++; end
      check_eq("bb_any_ack", bus.p0_ack | bus.p1_ack, 1);
      check_eq("bb_winner", bus.p1_ack, w);
      if (i == 2) begin bus.p0_req = 0; bus.p1_req = 0; end
      tick();
    end

    // Port 1 miss, clean victim, replay hit.
    bus.c_hit = 0;
    bus.p1_req = 1; bus.p1_addr = 32'h2004;
    push_exp(1, 32'hCAFEF00D, 0);
    wait_mem(0, "t3_fill_req");
    check_eq("t3_fill_we", bus.mem_we, 0);
    check_eq("t3_fill_addr", bus.mem_addr, 32'h2000);
    tick(); tick();
    bus.mem_rdata = line_a; bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    check_eq("t3_mem_req_drop", bus.mem_req, 0);
    check_eq("t3_c_load", bus.c_load, 1);
    check_eq("t3_load_data", bus.c_load_data, line_a);
    check_eq("t3_c_addr", bus.c_addr, 32'h2004);
    tick();
    check_eq("t3_c_load_held", bus.c_load, 1);
    bus.c_load_complete = 1; bus.c_hit = 1; bus.c_rdata = 32'hCAFEF00D;
    tick();
    bus.c_load_complete = 0;
    check_eq("t3_replay_read", {bus.c_read, bus.c_load}, 2'b10);
    wait_ack(1, "t3_ack");
    bus.p1_req = 0;
    tick();

    // Port 0 write miss with dirty victim.
    bus.c_hit = 0;
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h3008; bus.p0_wdata = 32'h1234_5678; bus.p0_size = 0;
    push_exp(0, 32'h0000_0055, 0);
    tick();
    check_eq("t4_c_write", {bus.c_write, bus.c_read}, 2'b10);
    check_eq("t4_c_wdata", bus.c_wdata, 32'h1234_5678);
    wait_mem(0, "t4_fill_req");
    check_eq("t4_fill_addr", bus.mem_addr, 32'h3000);
    bus.mem_rdata = line_b; bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    bus.c_save_data = 1; bus.c_wb_addr = 32'h700C; bus.c_wb_data = line_c;
    tick();
    check_eq("t4_wb_req", {bus.mem_req, bus.mem_we}, 2'b11);
    check_eq("t4_wb_addr", bus.mem_addr, 32'h7000);
    check_eq("t4_wb_data", bus.mem_wdata, line_c);
    check_eq("t4_load_in_wb", bus.c_load, 1);
    bus.c_save_data = 0; bus.c_wb_data = ~line_c; bus.c_wb_addr = 32'h0;
    tick();
    check_eq("t4_wb_data_stable", bus.mem_wdata, line_c);
    check_eq("t4_wb_addr_stable", bus.mem_addr, 32'h7000);
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    check_eq("t4_save_ready", bus.c_save_ready, 1);
    check_eq("t4_wb_req_drop", bus.mem_req, 0);
    tick();
    check_eq("t4_save_ready_pulse", bus.c_save_ready, 0);
    bus.c_load_complete = 1; bus.c_hit = 1; bus.c_rdata = 32'h0000_0055;
    tick();
    bus.c_load_complete = 0;
    check_eq("t4_replay_write", bus.c_write, 1);
    wait_ack(0, "t4_ack");
    bus.p0_req = 0; bus.p0_we = 0;
    tick();

    // Replay miss reports an error with zero data.
    bus.c_hit = 0; bus.c_rdata = 32'h0000_0099;
    bus.p0_req = 1; bus.p0_addr = 32'h4000;
    push_exp(0, 32'h0, 1);
    wait_mem(0, "t5_fill_req");
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    bus.c_load_complete = 1;
    tick();
    bus.c_load_complete = 0;
    wait_ack(0, "t5_ack");
    bus.p0_req = 0;
    tick();

    // Reset during write-back, then restart from IDLE.
    bus.p0_req = 1; bus.p0_addr = 32'h5000;
    wait_mem(0, "t6_fill_req");
    bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0;
    bus.c_save_data = 1; bus.c_wb_addr = 32'h7000; bus.c_wb_data = line_c;
    tick();
    bus.c_save_data = 0;
    check_eq("t6_in_wb", {bus.mem_req, bus.mem_we}, 2'b11);
    #1 rst = 0;
    #1;
    check_eq("t6_async_mem_req", bus.mem_req, 0);
    check_eq("t6_rst_load", bus.c_load, 0);
    repeat (2) tick();
    check_eq("t6_no_ack", {bus.p0_ack, bus.p1_ack}, 0);
    bus.c_hit = 1; bus.c_rdata = 32'h5A5A_5A5A;
    push_exp(0, 32'h5A5A_5A5A, 0);
    rst = 1;
    wait_ack(0, "t6_restart_ack");
    bus.p0_req = 0;
    tick(); tick();

    check_eq("q0_drained", q0.size(), 0);
    check_eq("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
